// File: rtl/top_if_if.sv
// Bus bundle for the instruction-fetch stage: debug/decode-side controls in,
// IF/ID register and status out. The stage itself connects through the slave modport.
interface top_if_if #(
    parameter int LENGTH_INSTRUCTION = 32,
    parameter int CANT_BITS_ADDR     = 11,
    parameter int CANT_BITS_CONTADOR = 32
);
    logic                          i_wr_program;
    logic [CANT_BITS_ADDR-1:0]     i_addr_program;
    logic [LENGTH_INSTRUCTION-1:0] i_data_program;
    logic                          i_start;
    logic                          i_enable_pipeline;
    logic                          i_enable_etapa;
    logic                          i_stall;
    logic                          i_branch_control;
    logic [CANT_BITS_ADDR-1:0]     i_branch_dir;

    logic [LENGTH_INSTRUCTION-1:0] o_instruction;
    logic [CANT_BITS_ADDR-1:0]     o_out_adder_pc;
    logic [CANT_BITS_ADDR-1:0]     o_contador_programa;
    logic                          o_halt_detected;
    logic                          o_running;
    logic [CANT_BITS_CONTADOR-1:0] o_contador_ciclos;

    modport master (
        output i_wr_program, i_addr_program, i_data_program, i_start,
               i_enable_pipeline, i_enable_etapa, i_stall,
               i_branch_control, i_branch_dir,
        input  o_instruction, o_out_adder_pc, o_contador_programa,
               o_halt_detected, o_running, o_contador_ciclos
    );

    modport slave (
        input  i_wr_program, i_addr_program, i_data_program, i_start,
               i_enable_pipeline, i_enable_etapa, i_stall,
               i_branch_control, i_branch_dir,
        output o_instruction, o_out_adder_pc, o_contador_programa,
               o_halt_detected, o_running, o_contador_ciclos
    );
endinterface

// File: rtl/top_if.sv
// MIPS instruction-fetch stage: PC, word-addressed program memory and IF/ID register.
// Optional macro IF_FLUSH_ON_BRANCH_EN squashes the branch delay slot to a NOP.
module top_if #(
    parameter int                          LENGTH_INSTRUCTION = 32,
    parameter int                          CANT_BITS_ADDR     = 11,
    parameter logic [LENGTH_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF,
    parameter int                          CANT_BITS_CONTADOR = 32
) (
    input  logic     i_clock,
    input  logic     i_soft_reset,
    top_if_if.slave  bus
);
    localparam int DEPTH = 2 ** CANT_BITS_ADDR;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t                        state_q, state_d;
    logic [CANT_BITS_ADDR-1:0]     pc_q, pc_d;
    logic [LENGTH_INSTRUCTION-1:0] instr_q, instr_d;
    logic [CANT_BITS_ADDR-1:0]     adder_q, adder_d;
    logic                          halt_q, halt_d;
    logic [CANT_BITS_CONTADOR-1:0] cnt_q, cnt_d;

    logic [LENGTH_INSTRUCTION-1:0] mem [DEPTH];
    logic [LENGTH_INSTRUCTION-1:0] fetch_word;
    logic [CANT_BITS_ADDR-1:0]     pc_plus1;
    logic                          advance;
    logic                          mem_we;

    assign fetch_word = mem[pc_q];
    assign pc_plus1   = pc_q + 1'b1;
    assign advance    = bus.i_enable_pipeline & bus.i_enable_etapa & ~bus.i_stall;
    assign mem_we     = (state_q == S_IDLE) & bus.i_wr_program;

    // NOTE: the program memory has no reset branch; clearing 2**N words costs a
    // reset fan-out for nothing, and the loader overwrites what it uses anyway.
    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            mem[bus.i_addr_program] <= bus.i_data_program;
        end
    end

    // NOTE: every output is defaulted to its held value first so no path through
    // the case leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        adder_d = adder_q;
        halt_d  = halt_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (advance) begin
                    adder_d = pc_plus1;
                    cnt_d   = cnt_q + 1'b1;
                    if (fetch_word == HALT_INSTRUCTION) begin
                        // Halt wins over a pending branch: PC freezes on the halt word.
                        instr_d = HALT_INSTRUCTION;
                        halt_d  = 1'b1;
                        state_d = S_HALTED;
                    end else begin
`ifdef IF_FLUSH_ON_BRANCH_EN
                        instr_d = bus.i_branch_control ? '0 : fetch_word;
`else
                        instr_d = fetch_word;
`endif
                        pc_d = bus.i_branch_control ? bus.i_branch_dir : pc_plus1;
                    end
                end
            end
            S_HALTED: begin
                if (bus.i_start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    halt_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            adder_q <= '0;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            adder_q <= adder_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_instruction       = instr_q;
    assign bus.o_out_adder_pc      = adder_q;
    assign bus.o_contador_programa = pc_q;
    assign bus.o_halt_detected     = halt_q;
    assign bus.o_running           = (state_q == S_RUN);
    assign bus.o_contador_ciclos   = cnt_q;
endmodule

// File: tb/tb_top_if.sv
// Self-checking bench for top_if: vector tables driven through a scoreboard queue,
// plus a hand-written mid-run reset sequence.
module tb_top_if;
    localparam int LI = 32;
    localparam int AW = 11;
    localparam int CW = 32;
`ifdef IF_FLUSH_ON_BRANCH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    typedef struct {
        bit          start;
        bit          wr;
        logic [AW-1:0] waddr;
        logic [LI-1:0] wdata;
        bit          pipe;
        bit          etapa;
        bit          stall;
        bit          br;
        logic [AW-1:0] dir;
        logic [LI-1:0] e_instr;
        logic [AW-1:0] e_adder;
        bit          chk_adder;
        logic [AW-1:0] e_pc;
        bit          e_halt;
        bit          e_run;
        logic [CW-1:0] e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    top_if_if #(.LENGTH_INSTRUCTION(LI), .CANT_BITS_ADDR(AW), .CANT_BITS_CONTADOR(CW)) bus ();

    top_if #(
        .LENGTH_INSTRUCTION(LI),
        .CANT_BITS_ADDR    (AW),
        .HALT_INSTRUCTION  (32'hFFFFFFFF),
        .CANT_BITS_CONTADOR(CW)
    ) dut (
        .i_clock     (clk),
        .i_soft_reset(rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(bit start, bit wr, logic [AW-1:0] wa, logic [LI-1:0] wd,
                                bit pipe, bit etapa, bit stall, bit br, logic [AW-1:0] dir,
                                logic [LI-1:0] ei, logic [AW-1:0] ea, bit ca,
                                logic [AW-1:0] ep, bit eh, bit er, logic [CW-1:0] ec);
        vec_t v;
        v.start = start; v.wr = wr; v.waddr = wa; v.wdata = wd;
        v.pipe = pipe; v.etapa = etapa; v.stall = stall; v.br = br; v.dir = dir;
        v.e_instr = ei; v.e_adder = ea; v.chk_adder = ca; v.e_pc = ep;
        v.e_halt = eh; v.e_run = er; v.e_cnt = ec;
        return v;
    endfunction

    // Advancing RUN cycle with optional branch.
    function automatic vec_t adv(bit br, logic [AW-1:0] dir, logic [LI-1:0] ei,
                                 logic [AW-1:0] ea, logic [AW-1:0] ep, logic [CW-1:0] ec);
        return mk(0, 0, '0, '0, 1, 1, 0, br, dir, ei, ea, 1, ep, 0, 1, ec);
    endfunction

    function automatic vec_t ld(logic [AW-1:0] a, logic [LI-1:0] d);
        return mk(0, 1, a, d, 0, 0, 0, 0, '0, '0, '0, 1, '0, 0, 0, '0);
    endfunction

    // Instruction expected in the IF/ID register for a delay slot.
    function automatic logic [LI-1:0] ds(logic [LI-1:0] w);
        return FLUSH ? '0 : w;
    endfunction

    task automatic drive(input vec_t v);
        bus.i_start           = v.start;
        bus.i_wr_program      = v.wr;
        bus.i_addr_program    = v.waddr;
        bus.i_data_program    = v.wdata;
        bus.i_enable_pipeline = v.pipe;
        bus.i_enable_etapa    = v.etapa;
        bus.i_stall           = v.stall;
        bus.i_branch_control  = v.br;
        bus.i_branch_dir      = v.dir;
    endtask

    task automatic run_vecs();
        vec_t e;
        foreach (vecs[i]) begin
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            vec_no++;
            check($sformatf("v%0d instr", vec_no), bus.o_instruction, e.e_instr);
            if (e.chk_adder)
                check($sformatf("v%0d adder_pc", vec_no), 32'(bus.o_out_adder_pc), 32'(e.e_adder));
            check($sformatf("v%0d pc", vec_no), 32'(bus.o_contador_programa), 32'(e.e_pc));
            check($sformatf("v%0d halt", vec_no), 32'(bus.o_halt_detected), 32'(e.e_halt));
            check($sformatf("v%0d running", vec_no), 32'(bus.o_running), 32'(e.e_run));
            check($sformatf("v%0d cycles", vec_no), bus.o_contador_ciclos, e.e_cnt);
        end
        vecs.delete();
    endtask

    task automatic push_first_run();
        vecs.push_back(mk(1, 0, '0, '0, 0, 0, 0, 0, '0, '0, '0, 1, '0, 0, 1, '0));
        vecs.push_back(adv(0, '0, 32'h20010005, 11'd1, 11'd1, 1));
        vecs.push_back(adv(0, '0, 32'h20020003, 11'd2, 11'd2, 2));
        vecs.push_back(adv(0, '0, 32'h00000000, 11'd3, 11'd3, 3));
        vecs.push_back(mk(0, 0, '0, '0, 1, 1, 0, 0, '0, 32'hFFFFFFFF, '0, 0, 11'd3, 1, 0, 4));
    endtask

    initial begin
        drive(mk(0, 0, '0, '0, 0, 0, 0, 0, '0, '0, '0, 0, '0, 0, 0, '0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset instr", bus.o_instruction, 32'h0);
        check("reset pc", 32'(bus.o_contador_programa), 32'h0);
        check("reset running", 32'(bus.o_running), 32'h0);
        check("reset cycles", bus.o_contador_ciclos, 32'h0);

        // Program load in IDLE, first run to the halt word, write while halted.
        vecs.push_back(ld(11'd0,    32'h20010005));
        vecs.push_back(ld(11'd1,    32'h20020003));
        vecs.push_back(ld(11'd2,    32'h00000000));
        vecs.push_back(ld(11'd3,    32'hFFFFFFFF));
        vecs.push_back(ld(11'd5,    32'hAAAA0005));
        vecs.push_back(ld(11'd10,   32'h1000000A));
        vecs.push_back(ld(11'd11,   32'h2000000B));
        vecs.push_back(ld(11'd20,   32'h30000014));
        vecs.push_back(ld(11'd2047, 32'h400007FF));
        push_first_run();
        vecs.push_back(mk(0, 1, 11'd0, 32'hDEADBEEF, 1, 1, 0, 0, '0, 32'hFFFFFFFF, '0, 0, 11'd3, 1, 0, 4));
        // Restart from HALTED: PC, halt and counter clear; IF/ID untouched.
        vecs.push_back(mk(1, 0, '0, '0, 0, 0, 0, 0, '0, 32'hFFFFFFFF, '0, 0, 11'd0, 0, 1, 0));
        vecs.push_back(adv(0, '0, 32'h20010005, 11'd1, 11'd1, 1));
        vecs.push_back(adv(1, 11'd10, ds(32'h20020003), 11'd2, 11'd10, 2));
        vecs.push_back(adv(0, '0, 32'h1000000A, 11'd11, 11'd11, 3));
        vecs.push_back(adv(1, 11'd5, ds(32'h2000000B), 11'd12, 11'd5, 4));
        // Stall with a pending branch; start and program write in RUN are ignored.
        vecs.push_back(mk(0, 0, '0, '0, 1, 1, 1, 1, 11'd20, ds(32'h2000000B), 11'd12, 1, 11'd5, 0, 1, 4));
        vecs.push_back(mk(1, 0, '0, '0, 1, 1, 1, 1, 11'd20, ds(32'h2000000B), 11'd12, 1, 11'd5, 0, 1, 4));
        vecs.push_back(mk(0, 1, 11'd5, 32'h0, 1, 1, 1, 1, 11'd20, ds(32'h2000000B), 11'd12, 1, 11'd5, 0, 1, 4));
        vecs.push_back(adv(1, 11'd20, ds(32'hAAAA0005), 11'd6, 11'd20, 5));
        vecs.push_back(adv(1, 11'd2047, ds(32'h30000014), 11'd21, 11'd2047, 6));
        vecs.push_back(adv(0, '0, 32'h400007FF, 11'd0, 11'd0, 7));
        // Step mode.
        vecs.push_back(mk(0, 0, '0, '0, 0, 1, 0, 0, '0, 32'h400007FF, 11'd0, 1, 11'd0, 0, 1, 7));
        vecs.push_back(adv(0, '0, 32'h20010005, 11'd1, 11'd1, 8));
        vecs.push_back(mk(1, 0, '0, '0, 0, 1, 0, 0, '0, 32'h20010005, 11'd1, 1, 11'd1, 0, 1, 8));
        vecs.push_back(adv(0, '0, 32'h20020003, 11'd2, 11'd2, 9));
        vecs.push_back(mk(0, 0, '0, '0, 1, 0, 0, 0, '0, 32'h20020003, 11'd2, 1, 11'd2, 0, 1, 9));
        vecs.push_back(adv(1, 11'd7, ds(32'h00000000), 11'd3, 11'd7, 10));
        run_vecs();

        // Reset in RUN at PC=7, with start and enables active: reset wins.
        drive(mk(1, 0, '0, '0, 1, 1, 0, 1, 11'd9, '0, '0, 0, '0, 0, 0, '0));
        rst = 1'b1;
        check("pre-reset pc", 32'(bus.o_contador_programa), 32'd7);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun reset instr", bus.o_instruction, 32'h0);
        check("midrun reset adder", 32'(bus.o_out_adder_pc), 32'h0);
        check("midrun reset pc", 32'(bus.o_contador_programa), 32'h0);
        check("midrun reset halt", 32'(bus.o_halt_detected), 32'h0);
        check("midrun reset running", 32'(bus.o_running), 32'h0);
        check("midrun reset cycles", bus.o_contador_ciclos, 32'h0);

        // IDLE does not advance; rerun shows memory survived reset.
        vecs.push_back(mk(0, 0, '0, '0, 1, 1, 0, 0, '0, '0, '0, 1, '0, 0, 0, '0));
        push_first_run();
        run_vecs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
